// File: rtl/coin_return_sequencer_pkg.sv
// Purpose: shared coin values, widths and FSM encodings for the coin return sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package coin_return_sequencer_pkg;

    localparam int kTotalBits = 31;
    localparam int kNumCoins  = 3;

    localparam int kCoinVal0 = 100;
    localparam int kCoinVal1 = 500;
    localparam int kCoinVal2 = 1000;

    // Return FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/coin_return_sequencer_coin_select.sv
// Purpose: combinational largest-fit coin picker for the remaining return amount.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows remain directly.
// Ports: remain (amount still owed), sel (one-hot, bit2 = COIN_VAL2), none_fit (remain < COIN_VAL0).
module coin_return_sequencer_coin_select
    import coin_return_sequencer_pkg::*;
#(
    parameter int TOTAL_BITS = kTotalBits,
    parameter int COIN_VAL0  = kCoinVal0,
    parameter int COIN_VAL1  = kCoinVal1,
    parameter int COIN_VAL2  = kCoinVal2
) (
    input  logic [TOTAL_BITS-1:0] remain,
    output logic [kNumCoins-1:0]  sel,
    output logic                  none_fit
);

    always_comb begin
        sel      = '0;
        none_fit = 1'b0;
        if (remain >= TOTAL_BITS'(COIN_VAL2)) begin
            sel = 3'b100;
        end else if (remain >= TOTAL_BITS'(COIN_VAL1)) begin
            sel = 3'b010;
        end else if (remain >= TOTAL_BITS'(COIN_VAL0)) begin
            sel = 3'b001;
        end else begin
            none_fit = 1'b1;
        end
    end

endmodule

// File: rtl/coin_return_sequencer.sv
// Purpose: latches current_total on a return request and pays it out one coin per hopper handshake, largest first.
// Latency: trigger sampled at edge N -> first o_coin_valid in cycle N+2; each coin costs 2 cycles plus hopper stalls.
// Backpressure: o_coin_valid/o_coin_sel hold until i_hopper_ready; with RETURN_TIMEOUT_EN defined a stall of
//   TIMEOUT_CYCLES aborts the return with o_fault set (macro undefined: waits forever, o_fault tied 0).
// Ports: clk, reset_n (async active-low), i_trigger_return, current_total, i_hopper_ready,
//   o_coin_valid, o_coin_sel, o_dispensed_value, o_busy, o_return_done, o_residual, o_fault.
module coin_return_sequencer
    import coin_return_sequencer_pkg::*;
#(
    parameter int TOTAL_BITS     = kTotalBits,
    parameter int COIN_VAL0      = kCoinVal0,
    parameter int COIN_VAL1      = kCoinVal1,
    parameter int COIN_VAL2      = kCoinVal2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] current_total,
    input  logic                  i_hopper_ready,
    output logic                  o_coin_valid,
    output logic [kNumCoins-1:0]  o_coin_sel,
    output logic [TOTAL_BITS-1:0] o_dispensed_value,
    output logic                  o_busy,
    output logic                  o_return_done,
    output logic [TOTAL_BITS-1:0] o_residual,
    output logic                  o_fault
);

    logic [1:0]            state;
    logic [TOTAL_BITS-1:0] remain;
    logic [kNumCoins-1:0]  sel_q;
    logic [kNumCoins-1:0]  pick_sel;
    logic                  none_fit;
    logic [TOTAL_BITS-1:0] sel_value;
    logic                  timeout_hit;

    coin_return_sequencer_coin_select #(
        .TOTAL_BITS (TOTAL_BITS),
        .COIN_VAL0  (COIN_VAL0),
        .COIN_VAL1  (COIN_VAL1),
        .COIN_VAL2  (COIN_VAL2)
    ) u_coin_select (
        .remain   (remain),
        .sel      (pick_sel),
        .none_fit (none_fit)
    );

    // Value of the coin currently presented; decoded from the registered select so it is
    // glitch-free and available in the handshake cycle itself.
    always_comb begin
        sel_value = '0;
        case (sel_q)
            3'b100:  sel_value = TOTAL_BITS'(COIN_VAL2);
            3'b010:  sel_value = TOTAL_BITS'(COIN_VAL1);
            3'b001:  sel_value = TOTAL_BITS'(COIN_VAL0);
            default: sel_value = '0;
        endcase
    end

    assign o_coin_valid      = (state == ST_ISSUE);
    assign o_coin_sel        = o_coin_valid ? sel_q : '0;
    assign o_dispensed_value = (o_coin_valid && i_hopper_ready) ? sel_value : '0;
    assign o_busy            = (state != ST_IDLE);
    assign o_return_done     = (state == ST_DONE);

`ifdef RETURN_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] stall_cnt;
    logic          fault_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of one coin.
    assign timeout_hit = o_coin_valid && !i_hopper_ready &&
                         (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign o_fault     = fault_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && i_trigger_return) begin
                fault_q <= 1'b0;
            end
            if (state == ST_SELECT) begin
                stall_cnt <= '0;
            end else if (o_coin_valid && !i_hopper_ready) begin
                if (timeout_hit) begin
                    fault_q <= 1'b1;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign o_fault        = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            remain     <= '0;
            sel_q      <= '0;
            o_residual <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_trigger_return) begin
                        remain     <= current_total;
                        o_residual <= '0;
                        state      <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (none_fit) begin
                        state <= ST_DONE;
                    end else begin
                        sel_q <= pick_sel;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Selection guarantees sel_value <= remain, so no underflow.
                    if (i_hopper_ready) begin
                        remain <= remain - sel_value;
                        state  <= ST_SELECT;
                    end else if (timeout_hit) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    o_residual <= remain;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_return_sequencer.sv
module tb_coin_return_sequencer;
    import coin_return_sequencer_pkg::*;

    localparam int TB = kTotalBits;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_trigger_return = 1'b0;
    logic [TB-1:0] current_total = '0;
    logic          i_hopper_ready = 1'b0;
    logic          o_coin_valid;
    logic [2:0]    o_coin_sel;
    logic [TB-1:0] o_dispensed_value;
    logic          o_busy;
    logic          o_return_done;
    logic [TB-1:0] o_residual;
    logic          o_fault;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_v;

    coin_return_sequencer #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_trigger_return  (i_trigger_return),
        .current_total     (current_total),
        .i_hopper_ready    (i_hopper_ready),
        .o_coin_valid      (o_coin_valid),
        .o_coin_sel        (o_coin_sel),
        .o_dispensed_value (o_dispensed_value),
        .o_busy            (o_busy),
        .o_return_done     (o_return_done),
        .o_residual        (o_residual),
        .o_fault           (o_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2:0] sel_for(input int v);
        case (v)
            1000:    return 3'b100;
            500:     return 3'b010;
            100:     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Greedy reference: queue the coins a return of 'total' must produce.
    task automatic load_expected(input int total, output int residual);
        int rem;
        rem = total;
        while (rem >= 1000) begin exp_q.push_back(1000); rem -= 1000; end
        while (rem >= 500)  begin exp_q.push_back(500);  rem -= 500;  end
        while (rem >= 100)  begin exp_q.push_back(100);  rem -= 100;  end
        residual = rem;
    endtask

    // Scoreboard: every accepted coin is popped and compared; outside handshakes the
    // dispensed value must be zero.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (o_coin_valid && i_hopper_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra_coin: dispensed %0d, required no coin", o_dispensed_value);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (o_dispensed_value !== TB'(exp_v) || o_coin_sel !== sel_for(exp_v)) begin
                        errors++;
                        $display("FAIL sb_coin: got value %0d sel %b, required value %0d sel %b",
                                 o_dispensed_value, o_coin_sel, exp_v, sel_for(exp_v));
                    end
                end
            end else if (o_dispensed_value !== '0) begin
                errors++;
                $display("FAIL sb_idle_value: got %0d, required 0", o_dispensed_value);
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({o_coin_valid, o_coin_sel, o_busy, o_return_done, o_fault} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b sel=%b busy=%b done=%b fault=%b, required all 0",
                     o_coin_valid, o_coin_sel, o_busy, o_return_done, o_fault);
        end
        checks++;
        if (o_residual !== '0 || o_dispensed_value !== '0) begin
            errors++;
            $display("FAIL reset_values: got residual=%0d dispensed=%0d, required 0/0", o_residual, o_dispensed_value);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b valid=%b, required 0/0", o_busy, o_coin_valid);
        end
    endtask

    task automatic test_full_return();
        int res, first_valid, done_at;
        @(posedge clk); #1;
        current_total = 1600; i_hopper_ready = 1'b1; i_trigger_return = 1'b1;
        load_expected(1600, res);
        first_valid = -1; done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            i_trigger_return = 1'b0;
            @(negedge clk);
            if (o_coin_valid && first_valid < 0) first_valid = c;
            if (o_return_done) done_at = c;
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (first_valid !== 2) begin errors++; $display("FAIL full_first_valid: got cycle %0d, required 2", first_valid); end
        checks++;
        if (done_at !== 8) begin errors++; $display("FAIL full_done_cycle: got cycle %0d, required 8", done_at); end
        checks++;
        if (o_residual !== TB'(res)) begin errors++; $display("FAIL full_residual: got %0d, required %0d", o_residual, res); end
        checks++;
        if (o_busy !== 1'b0 || o_return_done !== 1'b0) begin
            errors++; $display("FAIL full_idle_after: got busy=%b done=%b, required 0/0", o_busy, o_return_done);
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL full_coins_left: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_residual();
        int res, first_valid, done_at, busy_at_done;
        @(posedge clk); #1;
        current_total = 150; i_hopper_ready = 1'b1; i_trigger_return = 1'b1;
        load_expected(150, res);
        first_valid = -1; done_at = -1; busy_at_done = 0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            i_trigger_return = 1'b0;
            @(negedge clk);
            if (o_coin_valid && first_valid < 0) first_valid = c;
            if (o_return_done) begin done_at = c; busy_at_done = int'(o_busy); end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (first_valid !== 2 || done_at !== 4) begin
            errors++; $display("FAIL res_timing: got valid@%0d done@%0d, required 2/4", first_valid, done_at);
        end
        checks++;
        if (busy_at_done !== 1) begin errors++; $display("FAIL res_busy_in_done: got %0d, required 1", busy_at_done); end
        checks++;
        if (o_residual !== TB'(res)) begin errors++; $display("FAIL res_residual: got %0d, required %0d", o_residual, res); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL res_busy_after: got %b, required 0", o_busy); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_residual !== TB'(50)) begin errors++; $display("FAIL res_hold: got %0d, required 50", o_residual); end
    endtask

    task automatic test_zero_total();
        int res, first_valid, done_at;
        @(posedge clk); #1;
        current_total = 0; i_hopper_ready = 1'b1; i_trigger_return = 1'b1;
        load_expected(0, res);
        first_valid = -1; done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            i_trigger_return = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (o_residual !== '0) begin errors++; $display("FAIL zero_residual_clear: got %0d, required 0", o_residual); end
            end
            if (o_coin_valid && first_valid < 0) first_valid = c;
            if (o_return_done) done_at = c;
        end
        checks++;
        if (first_valid !== -1) begin errors++; $display("FAIL zero_no_coin: got valid@%0d, required none", first_valid); end
        checks++;
        if (done_at !== 2) begin errors++; $display("FAIL zero_done_cycle: got cycle %0d, required 2", done_at); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_residual !== TB'(res) || o_busy !== 1'b0) begin
            errors++; $display("FAIL zero_after: got residual=%0d busy=%b, required %0d/0", o_residual, o_busy, res);
        end
    endtask

    task automatic test_stall();
        int res, done_at;
        @(posedge clk); #1;
        current_total = 500; i_hopper_ready = 1'b0; i_trigger_return = 1'b1;
        load_expected(500, res);
        done_at = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            i_trigger_return = (c == 5);
            if (c == 5) current_total = 1000;
            i_hopper_ready = (c >= 12);
            @(negedge clk);
            if (c >= 2 && c <= 12) begin
                checks++;
                if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b010) begin
                    errors++;
                    $display("FAIL stall_hold_c%0d: got valid=%b sel=%b, required 1/010", c, o_coin_valid, o_coin_sel);
                end
            end
            if (o_return_done) done_at = c;
        end
        i_trigger_return = 1'b0;
        checks++;
        if (done_at !== 14) begin errors++; $display("FAIL stall_done_cycle: got cycle %0d, required 14", done_at); end
        checks++;
        if (o_fault !== 1'b0) begin errors++; $display("FAIL stall_fault_tied: got %b, required 0", o_fault); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_residual !== TB'(res) || exp_q.size() != 0) begin
            errors++; $display("FAIL stall_after: got residual=%0d pending=%0d, required %0d/0", o_residual, exp_q.size(), res);
        end
    endtask

    task automatic test_reset_mid_return();
        int res;
        @(posedge clk); #1;
        current_total = 2000; i_hopper_ready = 1'b1; i_trigger_return = 1'b1;
        load_expected(2000, res);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            i_trigger_return = 1'b0;
            i_hopper_ready = (c < 4);
            @(negedge clk);
        end
        checks++;
        if (o_coin_valid !== 1'b1 || o_coin_sel !== 3'b100) begin
            errors++; $display("FAIL rstmid_second_issue: got valid=%b sel=%b, required 1/100", o_coin_valid, o_coin_sel);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({o_coin_valid, o_coin_sel, o_busy, o_return_done, o_fault} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_async_flags: got valid=%b sel=%b busy=%b done=%b fault=%b, required all 0",
                     o_coin_valid, o_coin_sel, o_busy, o_return_done, o_fault);
        end
        checks++;
        if (o_residual !== '0 || o_dispensed_value !== '0) begin
            errors++; $display("FAIL rstmid_async_values: got residual=%0d dispensed=%0d, required 0/0", o_residual, o_dispensed_value);
        end
        checks++;
        if (exp_q.size() != 1) begin errors++; $display("FAIL rstmid_coins_paid: got %0d pending, required 1", exp_q.size()); end
        exp_q.delete();
        i_hopper_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_busy !== 1'b0 || o_coin_valid !== 1'b0) begin
                errors++; $display("FAIL rstmid_idle_c%0d: got busy=%b valid=%b, required 0/0", c, o_busy, o_coin_valid);
            end
        end
    endtask

    task automatic test_timeout();
        int done_at, fault_at_done, valid_at_done;
        @(posedge clk); #1;
        current_total = 100; i_hopper_ready = 1'b0; i_trigger_return = 1'b1;
        done_at = -1; fault_at_done = -1; valid_at_done = -1;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(posedge clk); #1;
            i_trigger_return = 1'b0;
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checks++;
                if (o_coin_valid !== 1'b1 || o_fault !== 1'b0) begin
                    errors++; $display("FAIL tmo_stall_c%0d: got valid=%b fault=%b, required 1/0", c, o_coin_valid, o_fault);
                end
            end
            if (o_return_done) begin done_at = c; fault_at_done = int'(o_fault); valid_at_done = int'(o_coin_valid); end
        end
        checks++;
        if (done_at !== 6) begin errors++; $display("FAIL tmo_done_cycle: got cycle %0d, required 6", done_at); end
        checks++;
        if (fault_at_done !== 1 || valid_at_done !== 0) begin
            errors++; $display("FAIL tmo_fault: got fault=%0d valid=%0d, required 1/0", fault_at_done, valid_at_done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_residual !== TB'(100) || o_fault !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL tmo_after: got residual=%0d fault=%b busy=%b, required 100/1/0", o_residual, o_fault, o_busy);
        end
        current_total = 0; i_trigger_return = 1'b1;
        @(posedge clk); #1;
        i_trigger_return = 1'b0;
        @(negedge clk);
        checks++;
        if (o_fault !== 1'b0) begin errors++; $display("FAIL tmo_fault_clear: got %b, required 0", o_fault); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_full_return();
        test_residual();
        test_zero_total();
`ifdef RETURN_TIMEOUT_EN
        test_timeout();
`else
        test_stall();
`endif
        test_reset_mid_return();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
